// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell, WIDTH+1 cycle op.
// Optional OVERFLOW_FLAG_EN adds the signed-overflow output ovf.

module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

module FullAdder_using2halfadders (
  input  logic a,
  input  logic b,
  input  logic Cin,
  output logic sum,
  output logic carry
);
  logic s0, c0, c1;

  half_adder u_ha0 (
    .a     (a),
    .b     (b),
    .sum   (s0),
    .carry (c0)
  );

  half_adder u_ha1 (
    .a     (s0),
    .b     (Cin),
    .sum   (sum),
    .carry (c1)
  );

  assign carry = c0 | c1;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             cy_q, cy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef OVERFLOW_FLAG_EN
  logic             ovf_q, ovf_d;
`endif

  logic             fa_sum;
  logic             fa_carry;
  logic [WIDTH-1:0] acc_nxt;

  FullAdder_using2halfadders u_fa (
    .a     (sa_q[0]),
    .b     (sb_q[0]),
    .Cin   (cy_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // New sum bit enters at the MSB so the LSB-first result lands aligned.
  assign acc_nxt = {fa_sum, acc_q[WIDTH-1:1]};

  // Next-state, datapath and result updates.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    acc_d   = acc_q;
    cy_d    = cy_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef OVERFLOW_FLAG_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          sa_d    = a;
          sb_d    = b;
          cy_d    = cin;
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d = acc_nxt;
        sa_d  = {1'b0, sa_q[WIDTH-1:1]};
        sb_d  = {1'b0, sb_q[WIDTH-1:1]};
        cy_d  = fa_carry;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          sum_d   = acc_nxt;
          cout_d  = fa_carry;
`ifdef OVERFLOW_FLAG_EN
          // cy_q is the carry into the MSB on this last step.
          ovf_d   = cy_q ^ fa_carry;
`endif
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      acc_q   <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      acc_q   <= acc_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef OVERFLOW_FLAG_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef OVERFLOW_FLAG_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8).
// Results are compared against a plain-arithmetic reference.

module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef OVERFLOW_FLAG_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef OVERFLOW_FLAG_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] ref_add(
    input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int unsigned t;
    t = int'(x) + int'(y) + int'(c);
    return t[W:0];
  endfunction

  function automatic logic ref_ovf(
    input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int s;
    s = int'($signed(x)) + int'($signed(y)) + int'(c);
    return (s > 127) || (s < -128);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic c);
    a = x; b = y; cin = c; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Steps until done or budget; reports cycles, busy cycles, sum held.
  task automatic wait_done(output int cyc, output int bcnt,
                           output bit held);
    logic [W-1:0] s0;
    s0 = sum; cyc = 0; bcnt = 0; held = 1'b1;
    while (!done && cyc < 40) begin
      if (busy) bcnt++;
      if (sum !== s0) held = 1'b0;
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    step(); step();
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_errors++;
      $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_errors++;
      $display("FAIL reset_done got %b exp 0", done); end
    n_checks++;
    if (sum !== 8'h00) begin n_errors++;
      $display("FAIL reset_sum got %h exp 00", sum); end
    n_checks++;
    if (cout !== 1'b0) begin n_errors++;
      $display("FAIL reset_cout got %b exp 0", cout); end
`ifdef OVERFLOW_FLAG_EN
    n_checks++;
    if (ovf !== 1'b0) begin n_errors++;
      $display("FAIL reset_ovf got %b exp 0", ovf); end
`endif
  endtask

  task automatic test_directed();
    logic [W-1:0] va[3] = '{8'h0F, 8'hFF, 8'h7F};
    logic [W-1:0] vb[3] = '{8'h01, 8'h01, 8'h01};
    logic         vc[3] = '{1'b0, 1'b1, 1'b0};
    logic [W:0]   e;
    int cyc, bc;
    bit held;
    for (int i = 0; i < 3; i++) begin
      e = ref_add(va[i], vb[i], vc[i]);
      issue(va[i], vb[i], vc[i]);
      wait_done(cyc, bc, held);
      n_checks++;
      if (cyc !== W) begin n_errors++;
        $display("FAIL dir%0d_latency got %0d exp %0d", i, cyc, W); end
      n_checks++;
      if (bc !== W) begin n_errors++;
        $display("FAIL dir%0d_busy got %0d exp %0d", i, bc, W); end
      n_checks++;
      if (!held) begin n_errors++;
        $display("FAIL dir%0d_hold got changed exp held", i); end
      n_checks++;
      if ({cout, sum} !== e) begin n_errors++;
        $display("FAIL dir%0d_sum got %b_%h exp %b_%h",
                 i, cout, sum, e[W], e[W-1:0]); end
`ifdef OVERFLOW_FLAG_EN
      n_checks++;
      if (ovf !== ref_ovf(va[i], vb[i], vc[i])) begin n_errors++;
        $display("FAIL dir%0d_ovf got %b exp %b", i, ovf,
                 ref_ovf(va[i], vb[i], vc[i])); end
`endif
      step();
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin n_errors++;
        $display("FAIL dir%0d_pulse got done=%b busy=%b exp 0 0",
                 i, done, busy); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] x, y;
    logic         c;
    logic [W:0]   e;
    int cyc, bc;
    bit held;
    for (int i = 0; i < 25; i++) begin
      x = W'($urandom); y = W'($urandom); c = 1'($urandom);
      e = ref_add(x, y, c);
      issue(x, y, c);
      wait_done(cyc, bc, held);
      n_checks++;
      if (cyc !== W || !held) begin n_errors++;
        $display("FAIL rnd%0d_timing got cyc=%0d held=%0b exp %0d 1",
                 i, cyc, held, W); end
      n_checks++;
      if ({cout, sum} !== e) begin n_errors++;
        $display("FAIL rnd%0d_sum %h+%h+%b got %b_%h exp %b_%h",
                 i, x, y, c, cout, sum, e[W], e[W-1:0]); end
`ifdef OVERFLOW_FLAG_EN
      n_checks++;
      if (ovf !== ref_ovf(x, y, c)) begin n_errors++;
        $display("FAIL rnd%0d_ovf got %b exp %b", i, ovf,
                 ref_ovf(x, y, c)); end
`endif
      if ($urandom_range(0, 1) == 1) step();
    end
  endtask

  task automatic test_back_to_back();
    logic [W:0] e1, e2;
    int cyc, bc;
    bit held;
    e1 = ref_add(8'h3C, 8'h55, 1'b1);
    e2 = ref_add(8'hA7, 8'h9E, 1'b0);
    issue(8'h3C, 8'h55, 1'b1);
    step(); step();
    issue(8'hEE, 8'hEE, 1'b1);
    wait_done(cyc, bc, held);
    n_checks++;
    if ({cout, sum} !== e1 || cyc !== W - 3) begin n_errors++;
      $display("FAIL ignore_start got %b_%h cyc=%0d exp %b_%h cyc=%0d",
               cout, sum, cyc, e1[W], e1[W-1:0], W - 3); end
    issue(8'hA7, 8'h9E, 1'b0);
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin n_errors++;
      $display("FAIL b2b_no_idle got busy=%b done=%b exp 1 0",
               busy, done); end
    wait_done(cyc, bc, held);
    n_checks++;
    if ({cout, sum} !== e2 || cyc !== W) begin n_errors++;
      $display("FAIL b2b_sum got %b_%h cyc=%0d exp %b_%h cyc=%0d",
               cout, sum, cyc, e2[W], e2[W-1:0], W); end
    step();
  endtask

  task automatic test_reset_mid();
    logic [W:0] e;
    int cyc, bc, seen;
    bit held;
    issue(8'h12, 8'h34, 1'b0);
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0)
    begin n_errors++;
      $display("FAIL midrst_clear got busy=%b done=%b sum=%h cout=%b exp 0",
               busy, done, sum, cout); end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) seen++;
      step();
    end
    n_checks++;
    if (seen !== 0) begin n_errors++;
      $display("FAIL midrst_quiet got %0d active cycles exp 0", seen); end
    e = ref_add(8'hC8, 8'h64, 1'b1);
    issue(8'hC8, 8'h64, 1'b1);
    wait_done(cyc, bc, held);
    n_checks++;
    if ({cout, sum} !== e || cyc !== W) begin n_errors++;
      $display("FAIL midrst_after got %b_%h cyc=%0d exp %b_%h cyc=%0d",
               cout, sum, cyc, e[W], e[W-1:0], W); end
    step();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
